// File: rtl/sample_writer.sv
// Streams samples into RAM region [base..limit]; writes land one cycle after the beat.
// s_ready comes straight from the state register; the source is held off outside WRITE.
module sample_writer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_limit,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_last_addr,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_limit;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_we;
  logic              r_full;
  logic [ADDR_W-1:0] r_last_addr;
  logic [ADDR_W:0]   r_count;

  logic w_write;
  logic w_beat;
  logic w_at_limit;

  assign w_write    = (r_state == ST_WRITE);
  assign w_beat     = w_write && i_s_valid;
  assign w_at_limit = (r_ptr == r_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_limit     <= '0;
      r_ptr       <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_we    <= 1'b0;
      r_full      <= 1'b0;
      r_last_addr <= '0;
      r_count     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            // Preloading last_addr with base covers a fill stopped before any beat.
            r_count     <= '0;
            r_last_addr <= i_base;
            if (i_limit >= i_base) begin
              r_limit <= i_limit;
              r_ptr   <= i_base;
              r_full  <= 1'b0;
              r_state <= ST_WRITE;
            end else begin
              r_full  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_WRITE: begin
          if (w_beat) begin
            r_mem_addr  <= r_ptr;
            r_mem_data  <= i_s_data;
            r_mem_we    <= 1'b1;
            r_last_addr <= r_ptr;
            r_count     <= r_count + 1'b1;
            // Holding ptr at limit avoids wrapping when limit is all-ones.
            if (w_at_limit) begin
              r_full  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
          if (i_stop) begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_s_ready   = w_write;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;
  assign o_mem_we    = r_mem_we;
  assign o_full      = r_full;
  assign o_last_addr = r_last_addr;
  assign o_count     = r_count;

endmodule

// File: tb/tb_sample_writer.sv
// Directed and randomized fills of sample_writer against a region-level model:
// the n-th accepted sample must land at base+n, capped at limit-base+1 samples.
module tb_sample_writer;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AW-1:0] i_base;
  logic [AW-1:0] i_limit;
  logic          i_stop;
  logic [DW-1:0] i_s_data;
  logic          i_s_valid;
  logic          o_s_ready;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_mem_we;
  logic          o_busy;
  logic          o_done;
  logic          o_full;
  logic [AW-1:0] o_last_addr;
  logic [AW:0]   o_count;

  int tests = 0;
  int fails = 0;

  sample_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_base     (i_base),
    .i_limit    (i_limit),
    .i_stop     (i_stop),
    .i_s_data   (i_s_data),
    .i_s_valid  (i_s_valid),
    .o_s_ready  (o_s_ready),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_we   (o_mem_we),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_full     (o_full),
    .o_last_addr(o_last_addr),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied just after a falling edge; outputs are read at the next falling edge.
  task automatic step(input logic v, input logic stp, input logic [DW-1:0] d);
    i_s_valid = v;
    i_stop    = stp;
    i_s_data  = d;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_s_ready), 0);
    chk({tag, "_addr"},  32'(o_mem_addr), 0);
    chk({tag, "_data"},  32'(o_mem_data), 0);
    chk({tag, "_we"},    32'(o_mem_we), 0);
    chk({tag, "_busy"},  32'(o_busy), 0);
    chk({tag, "_done"},  32'(o_done), 0);
    chk({tag, "_full"},  32'(o_full), 0);
    chk({tag, "_last"},  32'(o_last_addr), 0);
    chk({tag, "_count"}, 32'(o_count), 0);
  endtask

  // stop_at > 0: stop raised together with that beat; stop_at < 0: stop before any beat.
  task automatic fill(input string tag, input logic [AW-1:0] b, input logic [AW-1:0] l,
                      input int stop_at, input int vpct);
    int size, n, cyc;
    bit ended;
    logic v, stp;
    logic [DW-1:0] d;
    logic [AW-1:0] exp_last;
    i_start = 1'b1;
    i_base  = b;
    i_limit = l;
    step(1'b0, 1'b0, '0);
    i_start = 1'b0;
    i_base  = AW'($urandom);
    i_limit = AW'($urandom);
    if (l < b) begin
      chk({tag, "_empty_done"},  32'(o_done), 1);
      chk({tag, "_empty_full"},  32'(o_full), 1);
      chk({tag, "_empty_count"}, 32'(o_count), 0);
      chk({tag, "_empty_last"},  32'(o_last_addr), 32'(b));
      chk({tag, "_empty_we"},    32'(o_mem_we), 0);
      chk({tag, "_empty_ready"}, 32'(o_s_ready), 0);
      step(1'b0, 1'b0, '0);
      chk({tag, "_empty_idle"},  32'(o_busy), 0);
      return;
    end
    size  = int'(l) - int'(b) + 1;
    n     = 0;
    cyc   = 0;
    ended = 0;
    while (!ended && cyc < 4 * size + 200) begin
      chk({tag, "_ready"}, 32'(o_s_ready), 1);
      chk({tag, "_busy"},  32'(o_busy), 1);
      chk({tag, "_nodone"}, 32'(o_done), 0);
      v   = ($urandom_range(99) < vpct);
      stp = 1'b0;
      if (stop_at > 0 && n == stop_at - 1) begin
        v   = 1'b1;
        stp = 1'b1;
      end else if (stop_at < 0) begin
        v   = 1'b0;
        stp = 1'b1;
      end
      d       = DW'($urandom);
      i_start = 1'($urandom_range(1));
      step(v, stp, d);
      if (v) begin
        chk({tag, "_we"},   32'(o_mem_we), 1);
        chk({tag, "_addr"}, 32'(o_mem_addr), 32'(AW'(b + n)));
        chk({tag, "_data"}, 32'(o_mem_data), 32'(d));
        n++;
      end else begin
        chk({tag, "_gap_we"}, 32'(o_mem_we), 0);
      end
      if (n == size || stp) ended = 1;
      cyc++;
    end
    i_start = 1'b0;
    chk({tag, "_finished"}, 32'(ended), 1);
    exp_last = (n == 0) ? b : AW'(b + n - 1);
    chk({tag, "_done"},  32'(o_done), 1);
    chk({tag, "_dready"}, 32'(o_s_ready), 0);
    chk({tag, "_dbusy"}, 32'(o_busy), 1);
    chk({tag, "_count"}, 32'(o_count), 32'(n));
    chk({tag, "_full"},  32'(o_full), 32'(n == size));
    chk({tag, "_last"},  32'(o_last_addr), 32'(exp_last));
    step(1'b0, 1'b0, '0);
    chk({tag, "_idle_busy"}, 32'(o_busy), 0);
    chk({tag, "_idle_done"}, 32'(o_done), 0);
    chk({tag, "_idle_we"},   32'(o_mem_we), 0);
    step(1'b1, 1'b1, '0);
    chk({tag, "_stop_idle"},  32'(o_busy), 0);
    chk({tag, "_hold_count"}, 32'(o_count), 32'(n));
    chk({tag, "_hold_last"},  32'(o_last_addr), 32'(exp_last));
    chk({tag, "_hold_we"},    32'(o_mem_we), 0);
    step(1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [AW-1:0] rb, rl;
    int rs;
    rst = 1'b1; i_start = 1'b0; i_base = '0; i_limit = '0;
    i_stop = 1'b0; i_s_data = '0; i_s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    step(1'b0, 1'b0, '0);

    fill("normal",   16'h0010, 16'h0013, 0, 100);
    fill("throttle", 16'h0100, 16'h0102, 0, 40);
    fill("stop5",    16'h0200, 16'h02FF, 5, 70);
    fill("top",      16'hFFFF, 16'hFFFF, 0, 100);
    fill("inverted", 16'h0005, 16'h0004, 0, 100);
    fill("stop0",    16'h0300, 16'h03FF, -1, 50);

    // Abort a fill with reset on its third beat.
    i_start = 1'b1; i_base = 16'h0400; i_limit = 16'h040F;
    step(1'b0, 1'b0, '0);
    i_start = 1'b0;
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h22);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h33);
    chk_all_zero("midrst");
    rst = 1'b0;
    step(1'b0, 1'b0, '0);
    chk("midrst_nodone", 32'(o_done), 0);
    chk("midrst_we",     32'(o_mem_we), 0);
    fill("restart", 16'h0500, 16'h0503, 0, 100);

    for (int k = 0; k < 8; k++) begin
      rs = $urandom_range(12, 1);
      rb = (k < 2) ? AW'(16'hFFFF - $urandom_range(6)) : AW'($urandom);
      rl = (int'(rb) + rs - 1 > 16'hFFFF) ? 16'hFFFF : AW'(rb + rs - 1);
      fill("rand", rb, rl, (k % 3 == 2) ? int'($urandom_range(3, 1)) : 0, 60);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
